qa_drv_hc_channel_arbiter: RTL

// Shares the single CCI c0 (read) and c1 (write) request ports among N host-channel

---
 rtl/qa_drv_hc_channel_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/qa_drv_hc_channel_arbiter.sv
// Round-robin arbiter sharing the CCI c0 (read) and c1 (write) request ports among host-channel clients.
// Latency: combinational one-hot grant in cycle T, registered tx request valid for one cycle in T+1.
// Backpressure: c0/c1 almost-full and the outstanding-read credit limit suppress grants; clients hold requests.
module qa_drv_hc_channel_arbiter #(
    parameter int N_CLIENTS      = 3,
    parameter int N_RD_HDR_BITS  = 96,
    parameter int N_WR_HDR_BITS  = 96,
    parameter int N_WR_DATA_BITS = 512,
    parameter int MAX_RD_OUT     = 256
) (
    input  logic                                  clk,
    input  logic                                  reset_n,

    input  logic [N_CLIENTS-1:0]                  rd_req,
    input  logic [N_CLIENTS*N_RD_HDR_BITS-1:0]    rd_hdr,
    output logic [N_CLIENTS-1:0]                  rd_grant,

    input  logic [N_CLIENTS-1:0]                  wr_req,
    input  logic [N_CLIENTS*N_WR_HDR_BITS-1:0]    wr_hdr,
    input  logic [N_CLIENTS*N_WR_DATA_BITS-1:0]   wr_data,
    output logic [N_CLIENTS-1:0]                  wr_grant,

    input  logic                                  c0_almost_full,
    input  logic                                  c1_almost_full,
    input  logic                                  rd_rsp_en,

    output logic                                  tx0_valid,
    output logic [N_RD_HDR_BITS-1:0]              tx0_hdr,
    output logic                                  tx1_valid,
    output logic [N_WR_HDR_BITS-1:0]              tx1_hdr,
    output logic [N_WR_DATA_BITS-1:0]             tx1_data,

    output logic [$clog2(MAX_RD_OUT+1)-1:0]       rd_outstanding,
    output logic                                  err_underflow
);

    localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int CW = $clog2(MAX_RD_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RD_OUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // First requester at or after ptr, scanning upward with wrap.
    function automatic logic [N_CLIENTS-1:0] rr_pick(
        input logic [N_CLIENTS-1:0] req,
        input logic [PW-1:0]        ptr
    );
        logic [N_CLIENTS-1:0] gnt;
        logic                 found;
        int                   idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            idx = (int'(ptr) + k) % N_CLIENTS;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    // Pointer moves to the slot just past the winner so the winner goes to the back of the line.
    function automatic logic [PW-1:0] ptr_after(
        input logic [N_CLIENTS-1:0] gnt,
        input logic [PW-1:0]        ptr
    );
        logic [PW-1:0] nxt;
        nxt = ptr;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt[i]) begin
                nxt = (i == N_CLIENTS - 1) ? '0 : PW'(i + 1);
            end
        end
        return nxt;
    endfunction

    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             wr_ptr;
    logic                      rd_ok;
    logic                      wr_ok;
    logic                      rd_any;
    logic                      wr_any;
    logic [N_RD_HDR_BITS-1:0]  rd_hdr_sel;
    logic [N_WR_HDR_BITS-1:0]  wr_hdr_sel;
    logic [N_WR_DATA_BITS-1:0] wr_data_sel;

    // Reset gating keeps grants quiet while the arbiter state is being cleared.
    assign rd_ok    = reset_n && !c0_almost_full && (rd_outstanding < MAX_CNT);
    assign wr_ok    = reset_n && !c1_almost_full;
    assign rd_grant = rd_ok ? rr_pick(rd_req, rd_ptr) : '0;
    assign wr_grant = wr_ok ? rr_pick(wr_req, wr_ptr) : '0;
    assign rd_any   = |rd_grant;
    assign wr_any   = |wr_grant;

    // Select the winning client's payload; grants are one-hot so a priority mux is exact.
    always_comb begin
        rd_hdr_sel  = '0;
        wr_hdr_sel  = '0;
        wr_data_sel = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (rd_grant[i]) rd_hdr_sel  = rd_hdr[i*N_RD_HDR_BITS +: N_RD_HDR_BITS];
            if (wr_grant[i]) wr_hdr_sel  = wr_hdr[i*N_WR_HDR_BITS +: N_WR_HDR_BITS];
            if (wr_grant[i]) wr_data_sel = wr_data[i*N_WR_DATA_BITS +: N_WR_DATA_BITS];
        end
    end

    // Round-robin pointers advance only when their channel grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_any) rd_ptr <= ptr_after(rd_grant, rd_ptr);
            if (wr_any) wr_ptr <= ptr_after(wr_grant, wr_ptr);
        end
    end

    // Register the winning request onto tx; payload is only loaded on a grant and may be stale otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx0_valid <= 1'b0;
            tx0_hdr   <= '0;
            tx1_valid <= 1'b0;
            tx1_hdr   <= '0;
            tx1_data  <= '0;
        end else begin
            tx0_valid <= rd_any;
            tx1_valid <= wr_any;
            if (rd_any) tx0_hdr <= rd_hdr_sel;
            if (wr_any) begin
                tx1_hdr  <= wr_hdr_sel;
                tx1_data <= wr_data_sel;
            end
        end
    end

    // Outstanding-read credits: a grant and a retire in the same cycle cancel; retiring at zero is flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_outstanding <= '0;
            err_underflow  <= 1'b0;
        end else begin
            if (rd_any && !rd_rsp_en) begin
                rd_outstanding <= rd_outstanding + CNT_ONE;
            end else if (!rd_any && rd_rsp_en && (rd_outstanding != '0)) begin
                rd_outstanding <= rd_outstanding - CNT_ONE;
            end
            if (rd_rsp_en && (rd_outstanding == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
